// File: rtl/fifo_nic2noc_credit_pkg.sv
// Shared types and default sizing for the NIC-to-NoC credit/pointer stage.
package fifo_nic2noc_credit_pkg;

    localparam int unsigned DEF_N_TOT_OF_VC    = 6;
    localparam int unsigned DEF_N_BITS_POINTER = 5;
    localparam int unsigned DEF_FLIT_W         = 32;
    localparam int unsigned DEF_VC_DEPTH       = 4;
    localparam int unsigned DEF_N_BITS_CNT     = 3;
    localparam int unsigned DEF_N_BITS_VC      = 3;
    localparam int unsigned DEF_OUT_REG        = 1;

    typedef enum logic [1:0] {
        VC_IDLE     = 2'd0,
        VC_BUSY     = 2'd1,
        VC_DRAINING = 2'd2
    } vc_state_e;

endpackage

// File: rtl/fifo_nic2noc_credit_if.sv
// NIC-side and router-side signal bundle of the NIC-to-NoC credit stage.
interface fifo_nic2noc_credit_if
    import fifo_nic2noc_credit_pkg::*;
#(
    parameter int unsigned N_TOT_OF_VC    = DEF_N_TOT_OF_VC,
    parameter int unsigned N_BITS_POINTER = DEF_N_BITS_POINTER,
    parameter int unsigned FLIT_W         = DEF_FLIT_W,
    parameter int unsigned N_BITS_VC      = DEF_N_BITS_VC
);
    logic [N_TOT_OF_VC-1:0]                credit_signal_i;
    logic [FLIT_W-1:0]                     out_link_o;
    logic                                  is_valid_o;
    logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_i;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_i;
    logic [N_TOT_OF_VC-1:0]                release_pointer_i;
    logic [FLIT_W-1:0]                     in_link_i;
    logic                                  is_valid_i;
    logic [N_BITS_VC-1:0]                  in_vc_i;
    logic [N_TOT_OF_VC-1:0]                credit_signal_o;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o;
    logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_o;
    logic [N_TOT_OF_VC-1:0]                credit_avail_o;
    logic                                  err_o;

    modport slave (
        input  credit_signal_i, g_fifo_pointer_i, g_fifo_out_buffer_id_i,
               release_pointer_i, in_link_i, is_valid_i, in_vc_i,
        output out_link_o, is_valid_o, credit_signal_o, fifo_pointed_o,
               fifo_pointer_state_o, credit_avail_o, err_o
    );

    modport master (
        output credit_signal_i, g_fifo_pointer_i, g_fifo_out_buffer_id_i,
               release_pointer_i, in_link_i, is_valid_i, in_vc_i,
        input  out_link_o, is_valid_o, credit_signal_o, fifo_pointed_o,
               fifo_pointer_state_o, credit_avail_o, err_o
    );
endinterface

// File: rtl/fifo_nic2noc_credit_vc_credit_slot.sv
// One VC: lifecycle FSM, downstream credit counter, owner pointer, local error.
module fifo_nic2noc_credit_vc_credit_slot
    import fifo_nic2noc_credit_pkg::*;
#(
    parameter int unsigned N_BITS_POINTER = DEF_N_BITS_POINTER,
    parameter int unsigned VC_DEPTH       = DEF_VC_DEPTH,
    parameter int unsigned N_BITS_CNT     = DEF_N_BITS_CNT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      grant,
    input  logic [N_BITS_POINTER-1:0] grant_id,
    input  logic                      rel,
    input  logic                      dec,
    input  logic                      inc,
    output logic                      busy,
    output logic [N_BITS_POINTER-1:0] pointer,
    output logic                      avail,
    output logic                      err_c
);
    localparam logic [N_BITS_CNT-1:0] CNT_FULL = N_BITS_CNT'(VC_DEPTH);

    vc_state_e                 state_r, state_nxt;
    logic [N_BITS_CNT-1:0]     cnt_r, cnt_nxt;
    logic [N_BITS_POINTER-1:0] ptr_r;
    logic                      cnt_err, grant_err, load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= VC_IDLE;
            cnt_r   <= CNT_FULL;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            if (load) ptr_r <= grant_id;
        end
    end

    // Simultaneous flit and credit cancel out; under/overflow saturates and flags.
    always_comb begin
        cnt_nxt = cnt_r;
        cnt_err = 1'b0;
        if (dec && !inc) begin
            if (cnt_r == '0) cnt_err = 1'b1;
            else             cnt_nxt = cnt_r - N_BITS_CNT'(1);
        end else if (inc && !dec) begin
            if (cnt_r == CNT_FULL) cnt_err = 1'b1;
            else                   cnt_nxt = cnt_r + N_BITS_CNT'(1);
        end
    end

    // A VC becomes allocatable again only once all downstream credits are home.
    always_comb begin
        state_nxt = state_r;
        grant_err = 1'b0;
        load      = 1'b0;
        case (state_r)
            VC_IDLE: begin
                if (grant) begin
                    state_nxt = VC_BUSY;
                    load      = 1'b1;
                end
            end
            VC_BUSY: begin
                grant_err = grant;
                if (rel) state_nxt = (cnt_nxt == CNT_FULL) ? VC_IDLE : VC_DRAINING;
            end
            VC_DRAINING: begin
                grant_err = grant;
                if (cnt_nxt == CNT_FULL) state_nxt = VC_IDLE;
            end
            default: state_nxt = VC_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_r != VC_IDLE);
        avail   = (cnt_r != '0);
        pointer = ptr_r;
        err_c   = cnt_err | grant_err;
    end

endmodule

// File: rtl/fifo_nic2noc_credit.sv
// NIC-to-NoC stage: per-VC owner table with downstream credit tracking and
// an optionally registered flit link.
module fifo_nic2noc_credit
    import fifo_nic2noc_credit_pkg::*;
#(
    parameter int unsigned N_TOT_OF_VC    = DEF_N_TOT_OF_VC,
    parameter int unsigned N_BITS_POINTER = DEF_N_BITS_POINTER,
    parameter int unsigned FLIT_W         = DEF_FLIT_W,
    parameter int unsigned VC_DEPTH       = DEF_VC_DEPTH,
    parameter int unsigned N_BITS_CNT     = DEF_N_BITS_CNT,
    parameter int unsigned N_BITS_VC      = DEF_N_BITS_VC,
    parameter int unsigned OUT_REG        = DEF_OUT_REG
) (
    input logic                  clk,
    input logic                  rst,
    fifo_nic2noc_credit_if.slave bus
);
    logic [N_TOT_OF_VC-1:0]    dec, busy, avail, slot_err;
    logic [N_BITS_POINTER-1:0] ptr [N_TOT_OF_VC];
    logic                      vc_ok;
    logic                      err_r;

    assign vc_ok = (32'(bus.in_vc_i) < N_TOT_OF_VC);

    for (genvar gi = 0; gi < int'(N_TOT_OF_VC); gi++) begin : g_slot
        assign dec[gi] = bus.is_valid_i & vc_ok & (bus.in_vc_i == N_BITS_VC'(gi));

        fifo_nic2noc_credit_vc_credit_slot #(
            .N_BITS_POINTER (N_BITS_POINTER),
            .VC_DEPTH       (VC_DEPTH),
            .N_BITS_CNT     (N_BITS_CNT)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .grant    (bus.g_fifo_pointer_i[gi]),
            .grant_id (bus.g_fifo_out_buffer_id_i[gi*N_BITS_POINTER +: N_BITS_POINTER]),
            .rel      (bus.release_pointer_i[gi]),
            .dec      (dec[gi]),
            .inc      (bus.credit_signal_i[gi]),
            .busy     (busy[gi]),
            .pointer  (ptr[gi]),
            .avail    (avail[gi]),
            .err_c    (slot_err[gi])
        );

        assign bus.fifo_pointed_o[gi*N_BITS_POINTER +: N_BITS_POINTER] = ptr[gi];
    end

    // Sticky until reset: any slot fault or a flit tagged with a non-existent VC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_r <= 1'b0;
        else     err_r <= err_r | (|slot_err) | (bus.is_valid_i & ~vc_ok);
    end

    assign bus.err_o                = err_r;
    assign bus.fifo_pointer_state_o = busy;
    assign bus.credit_avail_o       = avail;
    assign bus.credit_signal_o      = bus.credit_signal_i;

    if (OUT_REG != 0) begin : g_link_reg
        logic [FLIT_W-1:0] link_r;
        logic              valid_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                link_r  <= '0;
                valid_r <= 1'b0;
            end else begin
                link_r  <= bus.in_link_i;
                valid_r <= bus.is_valid_i;
            end
        end

        assign bus.out_link_o = link_r;
        assign bus.is_valid_o = valid_r;
    end else begin : g_link_bypass
        assign bus.out_link_o = bus.in_link_i;
        assign bus.is_valid_o = bus.is_valid_i;
    end

endmodule

// File: tb/tb_fifo_nic2noc_credit.sv
// Directed table-driven bench for fifo_nic2noc_credit (OUT_REG = 1 build).
module tb_fifo_nic2noc_credit;
    localparam int unsigned NV = 6;
    localparam int unsigned NP = 5;
    localparam int unsigned FW = 32;
    localparam int unsigned NVB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_nic2noc_credit_if #(.N_TOT_OF_VC(NV), .N_BITS_POINTER(NP), .FLIT_W(FW), .N_BITS_VC(NVB)) bus ();

    fifo_nic2noc_credit #(
        .N_TOT_OF_VC(NV), .N_BITS_POINTER(NP), .FLIT_W(FW), .VC_DEPTH(4),
        .N_BITS_CNT(3), .N_BITS_VC(NVB), .OUT_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          r;
        logic [5:0]  g;
        logic [4:0]  id;
        logic [5:0]  rl;
        bit          v;
        logic [2:0]  vc;
        logic [5:0]  cr;
        logic [5:0]  est;
        logic [5:0]  eav;
        bit          eerr;
        int          pvc;
        logic [4:0]  pexp;
    } vec_t;

    vec_t vecs [29];
    vec_t h;

    function automatic vec_t mk(bit r, logic [5:0] g, logic [4:0] id, logic [5:0] rl, bit v,
                                logic [2:0] vc, logic [5:0] cr, logic [5:0] est, logic [5:0] eav,
                                bit eerr, int pvc, logic [4:0] pexp);
        vec_t t;
        t.r = r; t.g = g; t.id = id; t.rl = rl; t.v = v; t.vc = vc; t.cr = cr;
        t.est = est; t.eav = eav; t.eerr = eerr; t.pvc = pvc; t.pexp = pexp;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [5:0] est, input logic [5:0] eav,
                               input bit eerr, input int pvc, input logic [4:0] pexp);
        chk("state", idx, 64'(bus.fifo_pointer_state_o), 64'(est));
        chk("avail", idx, 64'(bus.credit_avail_o), 64'(eav));
        chk("err", idx, 64'(bus.err_o), 64'(eerr));
        chk("ptr", idx, 64'(bus.fifo_pointed_o[pvc*NP +: NP]), 64'(pexp));
    endtask

    task automatic apply(input vec_t t, input int k);
        logic [FW-1:0] flit;
        flit = 32'hA000_0000 | 32'(k);
        bus.g_fifo_pointer_i       = t.g;
        bus.g_fifo_out_buffer_id_i = {NV{t.id}};
        bus.release_pointer_i      = t.rl;
        bus.is_valid_i             = t.v;
        bus.in_vc_i                = t.vc;
        bus.in_link_i              = flit;
        bus.credit_signal_i        = t.cr;
        rst                        = t.r;
        @(posedge clk);
        #1;
        check_state(k, t.est, t.eav, t.eerr, t.pvc, t.pexp);
        chk("valid_o", k, 64'(bus.is_valid_o), 64'(t.v & ~t.r));
        if (t.v) chk("link", k, 64'(bus.out_link_o), 64'(flit));
        chk("credit_o", k, 64'(bus.credit_signal_o), 64'(t.cr));
        if (t.r) rst = 1'b0;
    endtask

    initial begin
        //             r  g          id rl         v  vc cr         est    eav    e  pvc ptr
        vecs[0]  = mk(0, 6'b000100, 5, 6'b000000, 0, 0, 6'b000000, 6'h04, 6'h3f, 0, 2, 5);
        vecs[1]  = mk(0, 6'b000010, 3, 6'b000000, 0, 0, 6'b000000, 6'h06, 6'h3f, 0, 1, 3);
        vecs[2]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 6'b000000, 6'h06, 6'h3f, 0, 2, 5);
        vecs[3]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 6'b000010, 6'h06, 6'h3f, 0, 1, 3);
        vecs[4]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 6'b000000, 6'h06, 6'h3f, 0, 1, 3);
        vecs[5]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 6'b000000, 6'h06, 6'h3f, 0, 1, 3);
        vecs[6]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 6'b000000, 6'h06, 6'h3d, 0, 1, 3);
        vecs[7]  = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000010, 6'h06, 6'h3f, 0, 1, 3);
        vecs[8]  = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h06, 6'h3f, 0, 2, 5);
        vecs[9]  = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h06, 6'h3f, 0, 2, 5);
        vecs[10] = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h06, 6'h3f, 0, 2, 5);
        vecs[11] = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h06, 6'h3b, 0, 2, 5);
        vecs[12] = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h06, 6'h3b, 1, 2, 5);
        vecs[13] = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000100, 6'h06, 6'h3f, 1, 2, 5);
        vecs[14] = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000100, 6'h06, 6'h3f, 1, 2, 5);
        vecs[15] = mk(0, 6'b000000, 0, 6'b000100, 0, 0, 6'b000000, 6'h06, 6'h3f, 1, 2, 5);
        vecs[16] = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000100, 6'h06, 6'h3f, 1, 2, 5);
        vecs[17] = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000100, 6'h02, 6'h3f, 1, 2, 5);
        vecs[18] = mk(1, 6'b000000, 0, 6'b000000, 0, 0, 6'b000000, 6'h00, 6'h3f, 0, 2, 0);
        vecs[19] = mk(0, 6'b000001, 7, 6'b000000, 0, 0, 6'b000000, 6'h01, 6'h3f, 0, 0, 7);
        vecs[20] = mk(0, 6'b000001, 9, 6'b000000, 0, 0, 6'b000000, 6'h01, 6'h3f, 1, 0, 7);
        vecs[21] = mk(1, 6'b000000, 0, 6'b000000, 0, 0, 6'b000000, 6'h00, 6'h3f, 0, 0, 0);
        vecs[22] = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b001000, 6'h00, 6'h3f, 1, 3, 0);
        vecs[23] = mk(1, 6'b000000, 0, 6'b000000, 0, 0, 6'b000000, 6'h00, 6'h3f, 0, 2, 0);
        vecs[24] = mk(0, 6'b000000, 0, 6'b000000, 1, 6, 6'b000000, 6'h00, 6'h3f, 1, 2, 0);
        vecs[25] = mk(1, 6'b000000, 0, 6'b000000, 0, 0, 6'b000000, 6'h00, 6'h3f, 0, 2, 0);
        vecs[26] = mk(0, 6'b000100, 5, 6'b000100, 0, 0, 6'b000000, 6'h04, 6'h3f, 0, 2, 5);
        vecs[27] = mk(0, 6'b000000, 0, 6'b001000, 0, 0, 6'b000000, 6'h04, 6'h3f, 0, 2, 5);
        vecs[28] = mk(0, 6'b000000, 0, 6'b000100, 0, 0, 6'b000000, 6'h00, 6'h3f, 0, 2, 5);

        bus.g_fifo_pointer_i       = '0;
        bus.g_fifo_out_buffer_id_i = '0;
        bus.release_pointer_i      = '0;
        bus.is_valid_i             = 1'b0;
        bus.in_vc_i                = '0;
        bus.in_link_i              = '0;
        bus.credit_signal_i        = '0;

        repeat (2) @(posedge clk);
        #1;
        check_state(-1, 6'h00, 6'h3f, 1'b0, 2, 5'd0);
        chk("valid_o", -1, 64'(bus.is_valid_o), 64'd0);
        chk("link", -1, 64'(bus.out_link_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) apply(vecs[i], i);

        // Async reset in the middle of a drain, with err already raised.
        h = mk(0, 6'b000100, 5, 6'b000000, 0, 0, 6'b000000, 6'h04, 6'h3f, 0, 2, 5); apply(h, 100);
        h = mk(0, 6'b000000, 0, 6'b000000, 1, 2, 6'b000000, 6'h04, 6'h3f, 0, 2, 5); apply(h, 101);
        h = mk(0, 6'b000000, 0, 6'b000100, 0, 0, 6'b000000, 6'h04, 6'h3f, 0, 2, 5); apply(h, 102);
        h = mk(0, 6'b000000, 0, 6'b000000, 1, 7, 6'b000000, 6'h04, 6'h3f, 1, 2, 5); apply(h, 103);
        bus.is_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_state(104, 6'h00, 6'h3f, 1'b0, 2, 5'd0);
        chk("valid_o", 104, 64'(bus.is_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Late credit for the discarded drain is an overflow on a full counter.
        h = mk(0, 6'b000000, 0, 6'b000000, 0, 0, 6'b000100, 6'h00, 6'h3f, 1, 2, 0); apply(h, 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
